// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared opcodes, forwarding selects and M-engine state type for the execute stage
package ex_pkg;

    // ALU opcodes
    localparam logic [3:0] ALU_OP_ADD    = 4'd0;
    localparam logic [3:0] ALU_OP_SUB    = 4'd1;
    localparam logic [3:0] ALU_OP_SLL    = 4'd2;
    localparam logic [3:0] ALU_OP_SLT    = 4'd3;
    localparam logic [3:0] ALU_OP_SLTU   = 4'd4;
    localparam logic [3:0] ALU_OP_XOR    = 4'd5;
    localparam logic [3:0] ALU_OP_SRL    = 4'd6;
    localparam logic [3:0] ALU_OP_SRA    = 4'd7;
    localparam logic [3:0] ALU_OP_OR     = 4'd8;
    localparam logic [3:0] ALU_OP_AND    = 4'd9;
    localparam logic [3:0] ALU_OP_PASS_B = 4'd10;

    // M-extension funct3 codes
    localparam logic [2:0] MD_OP_MUL    = 3'b000;
    localparam logic [2:0] MD_OP_MULH   = 3'b001;
    localparam logic [2:0] MD_OP_MULHSU = 3'b010;
    localparam logic [2:0] MD_OP_MULHU  = 3'b011;
    localparam logic [2:0] MD_OP_DIV    = 3'b100;
    localparam logic [2:0] MD_OP_DIVU   = 3'b101;
    localparam logic [2:0] MD_OP_REM    = 3'b110;
    localparam logic [2:0] MD_OP_REMU   = 3'b111;

    // Forwarding mux selects (2'b11 falls back to the register value)
    localparam logic [1:0] FWD_REG    = 2'b00;
    localparam logic [1:0] FWD_EX_MEM = 2'b01;
    localparam logic [1:0] FWD_MEM_WB = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

    // funct3 bit 2 separates divides from multiplies
    function automatic logic md_is_div(input logic [2:0] op);
        return op[2];
    endfunction

    // REM/REMU return the remainder rather than the quotient
    function automatic logic md_is_rem(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - single-cycle integer ALU
module alu
    import ex_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [3:0]      op_i,
    output logic [XLEN-1:0] result_o
);

    localparam int SW = $clog2(XLEN);

    logic [SW-1:0] shamt;

    // Combinational operation select; shifts use the low log2(XLEN) bits of b
    always_comb begin
        shamt    = b_i[SW-1:0];
        result_o = '0;
        case (op_i)
            ALU_OP_ADD:    result_o = a_i + b_i;
            ALU_OP_SUB:    result_o = a_i - b_i;
            ALU_OP_SLL:    result_o = a_i << shamt;
            ALU_OP_SLT:    result_o = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
            ALU_OP_SLTU:   result_o = {{(XLEN-1){1'b0}}, a_i < b_i};
            ALU_OP_XOR:    result_o = a_i ^ b_i;
            ALU_OP_SRL:    result_o = a_i >> shamt;
            ALU_OP_SRA:    result_o = $unsigned($signed(a_i) >>> shamt);
            ALU_OP_OR:     result_o = a_i | b_i;
            ALU_OP_AND:    result_o = a_i & b_i;
            ALU_OP_PASS_B: result_o = b_i;
            default:       result_o = '0;
        endcase
    end

endmodule

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - iterative multiply/divide engine with sign fixup
module muldiv_iter
    import ex_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            flush_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam int AW = 2 * XLEN;
    localparam logic [CW-1:0]   MUL_LAST = CW'(XLEN / MUL_STEP - 1);
    localparam logic [CW-1:0]   DIV_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   acc_q, acc_d;      // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [XLEN-1:0] opb_q, opb_d;      // multiplicand or divisor magnitude
    logic [2:0]      op_q, op_d;
    logic            res_neg_q, res_neg_d;   // product sign / quotient sign
    logic            rem_neg_q, rem_neg_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;

    logic [XLEN+MUL_STEP-1:0] mul_sum;
    logic [AW-1:0]            mul_next, prod_fix;
    logic [XLEN:0]            div_diff;
    logic [AW-1:0]            div_next;
    logic [XLEN-1:0]          quo, rem, mul_res, div_res;

    // Operand signedness and magnitudes for the op being offered at accept
    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (op_i)
            MD_OP_MULH, MD_OP_DIV, MD_OP_REM: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            MD_OP_MULHSU: a_signed = 1'b1;
            MD_OP_MUL, MD_OP_MULHU, MD_OP_DIVU, MD_OP_REMU: begin
                a_signed = 1'b0;
                b_signed = 1'b0;
            end
        endcase
        a_neg = a_signed & a_i[XLEN-1];
        b_neg = b_signed & b_i[XLEN-1];
        a_mag = a_neg ? -a_i : a_i;
        b_mag = b_neg ? -b_i : b_i;
    end

    // One iteration of each engine plus the sign-corrected final results
    always_comb begin
        mul_sum  = {{MUL_STEP{1'b0}}, acc_q[AW-1:XLEN]}
                 + ({{MUL_STEP{1'b0}}, opb_q} * {{XLEN{1'b0}}, acc_q[MUL_STEP-1:0]});
        mul_next = {mul_sum, acc_q[XLEN-1:MUL_STEP]};
        prod_fix = res_neg_q ? -mul_next : mul_next;
        mul_res  = (op_q == MD_OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[AW-1:XLEN];

        // Trial subtract of the shifted partial remainder; the top bit is the borrow
        div_diff = acc_q[AW-1:XLEN-1] - {1'b0, opb_q};
        div_next = div_diff[XLEN] ? {acc_q[AW-2:0], 1'b0}
                                  : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        quo      = div_next[XLEN-1:0];
        rem      = div_next[AW-1:XLEN];
        div_res  = md_is_rem(op_q) ? (rem_neg_q ? -rem : rem)
                                   : (res_neg_q ? -quo : quo);
    end

    // FSM next state, counter and accumulator updates; flush beats accept
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        op_d      = op_q;
        res_neg_d = res_neg_q;
        rem_neg_d = rem_neg_q;
        result_d  = result_q;
        if (flush_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        op_d      = op_i;
                        cnt_d     = '0;
                        opb_d     = b_mag;
                        res_neg_d = a_neg ^ b_neg;
                        rem_neg_d = a_neg;
                        if (md_is_div(op_i) && (b_i == '0)) begin
                            result_d = md_is_rem(op_i) ? a_i : '1;
                            state_d  = ST_DONE;
                        end else if (md_is_div(op_i) && a_signed && (a_i == MIN_NEG) && (b_i == '1)) begin
                            result_d = md_is_rem(op_i) ? '0 : MIN_NEG;
                            state_d  = ST_DONE;
                        end else if (md_is_div(op_i)) begin
                            acc_d   = {{XLEN{1'b0}}, a_mag};
                            state_d = ST_DIV;
                        end else begin
                            acc_d   = {{XLEN{1'b0}}, b_mag};
                            opb_d   = a_mag;
                            state_d = ST_MUL;
                        end
                    end
                end
                ST_MUL: begin
                    acc_d = mul_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == MUL_LAST) begin
                        result_d = mul_res;
                        cnt_d    = '0;
                        state_d  = ST_DONE;
                    end
                end
                ST_DIV: begin
                    acc_d = div_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == DIV_LAST) begin
                        result_d = div_res;
                        cnt_d    = '0;
                        state_d  = ST_DONE;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Engine state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            op_q      <= '0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            op_q      <= op_d;
            res_neg_q <= res_neg_d;
            rem_neg_q <= rem_neg_d;
            result_q  <= result_d;
        end
    end

    assign busy_o   = (state_q == ST_MUL) || (state_q == ST_DIV);
    assign done_o   = (state_q == ST_DONE);
    assign result_o = result_q;

endmodule

// File: rtl/ex_stage_md.sv
// rtl/ex_stage_md.sv - RV32IM execute stage with forwarding, ALU and iterative M engine
module ex_stage_md
    import ex_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [XLEN-1:0] imm_ext_i,
    input  logic            alu_src_i,
    input  logic [3:0]      alu_op_i,
    input  logic            md_en_i,
    input  logic [2:0]      md_op_i,
    input  logic [XLEN-1:0] ex_mem_result_i,
    input  logic [XLEN-1:0] mem_wb_result_i,
    input  logic [1:0]      forward_a_sel_i,
    input  logic [1:0]      forward_b_sel_i,
    input  logic            flush_i,
    output logic [XLEN-1:0] result_o,
    output logic            zero_flag_o,
    output logic            valid_o,
    output logic            stall_o
);

    logic [XLEN-1:0] op_a, rs2_fwd, op_b, alu_result, md_result;
    logic            md_start, md_busy, md_done;

    // Forwarding muxes; M ops always take the forwarded rs2, never the immediate
    always_comb begin
        case (forward_a_sel_i)
            FWD_REG:    op_a = rs1_data_i;
            FWD_EX_MEM: op_a = ex_mem_result_i;
            FWD_MEM_WB: op_a = mem_wb_result_i;
            default:    op_a = rs1_data_i;
        endcase
        case (forward_b_sel_i)
            FWD_REG:    rs2_fwd = rs2_data_i;
            FWD_EX_MEM: rs2_fwd = ex_mem_result_i;
            FWD_MEM_WB: rs2_fwd = mem_wb_result_i;
            default:    rs2_fwd = rs2_data_i;
        endcase
        op_b = alu_src_i ? imm_ext_i : rs2_fwd;
    end

    assign md_start = valid_i & md_en_i;

    alu #(
        .XLEN (XLEN)
    ) u_alu (
        .a_i      (op_a),
        .b_i      (op_b),
        .op_i     (alu_op_i),
        .result_o (alu_result)
    );

    muldiv_iter #(
        .XLEN     (XLEN),
        .MUL_STEP (MUL_STEP)
    ) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (md_start),
        .flush_i  (flush_i),
        .op_i     (md_op_i),
        .a_i      (op_a),
        .b_i      (rs2_fwd),
        .busy_o   (md_busy),
        .done_o   (md_done),
        .result_o (md_result)
    );

    // Output mux: reset forces idle outputs, flush masks handshakes, DONE presents the M result
    always_comb begin
        result_o = alu_result;
        valid_o  = 1'b0;
        stall_o  = 1'b0;
        if (!rst_n) begin
            result_o = '0;
        end else if (md_done) begin
            result_o = md_result;
            valid_o  = ~flush_i;
        end else if (md_busy) begin
            result_o = md_result;
            stall_o  = ~flush_i;
        end else if (md_start) begin
            stall_o  = ~flush_i;
        end else begin
            valid_o  = valid_i & ~flush_i;
        end
    end

    assign zero_flag_o = (result_o == '0);

endmodule

// File: tb/tb_ex_stage_md.sv
// tb/tb_ex_stage_md.sv - self-checking bench for ex_stage_md
module tb_ex_stage_md;
    import ex_pkg::*;

    localparam int XLEN     = 32;
    localparam int MUL_STEP = 4;
    localparam int LAT_MUL  = XLEN / MUL_STEP + 2;
    localparam int LAT_DIV  = XLEN + 2;
    localparam int LAT_FAST = 2;
    localparam int LAT_ALU  = 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            valid_i;
    logic [XLEN-1:0] rs1_data_i, rs2_data_i, imm_ext_i;
    logic            alu_src_i;
    logic [3:0]      alu_op_i;
    logic            md_en_i;
    logic [2:0]      md_op_i;
    logic [XLEN-1:0] ex_mem_result_i, mem_wb_result_i;
    logic [1:0]      forward_a_sel_i, forward_b_sel_i;
    logic            flush_i;
    logic [XLEN-1:0] result_o;
    logic            zero_flag_o, valid_o, stall_o;

    always #5 clk = ~clk;

    ex_stage_md #(
        .XLEN     (XLEN),
        .MUL_STEP (MUL_STEP)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .valid_i         (valid_i),
        .rs1_data_i      (rs1_data_i),
        .rs2_data_i      (rs2_data_i),
        .imm_ext_i       (imm_ext_i),
        .alu_src_i       (alu_src_i),
        .alu_op_i        (alu_op_i),
        .md_en_i         (md_en_i),
        .md_op_i         (md_op_i),
        .ex_mem_result_i (ex_mem_result_i),
        .mem_wb_result_i (mem_wb_result_i),
        .forward_a_sel_i (forward_a_sel_i),
        .forward_b_sel_i (forward_b_sel_i),
        .flush_i         (flush_i),
        .result_o        (result_o),
        .zero_flag_o     (zero_flag_o),
        .valid_o         (valid_o),
        .stall_o         (stall_o)
    );

    typedef struct {
        logic        alu_src;
        logic [3:0]  alu_op;
        logic        md_en;
        logic [2:0]  md_op;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [31:0] exm;
        logic [31:0] mwb;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    function automatic vec_t mk(input logic alu_src, input logic [3:0] alu_op, input logic md_en,
                                input logic [2:0] md_op, input logic [1:0] fa, input logic [1:0] fb,
                                input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                                input logic [31:0] exm, input logic [31:0] mwb, input logic [31:0] exp,
                                input int lat);
        vec_t v;
        v.alu_src = alu_src; v.alu_op = alu_op; v.md_en = md_en; v.md_op = md_op;
        v.fa = fa; v.fb = fb; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
        v.exm = exm; v.mwb = mwb; v.exp = exp; v.lat = lat;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        valid_i         = 1'b1;
        flush_i         = 1'b0;
        alu_src_i       = v.alu_src;
        alu_op_i        = v.alu_op;
        md_en_i         = v.md_en;
        md_op_i         = v.md_op;
        forward_a_sel_i = v.fa;
        forward_b_sel_i = v.fb;
        rs1_data_i      = v.rs1;
        rs2_data_i      = v.rs2;
        imm_ext_i       = v.imm;
        ex_mem_result_i = v.exm;
        mem_wb_result_i = v.mwb;
    endtask

    // Issue one instruction, wait for valid_o (operands scrambled while busy), then compare
    task automatic run_vec(input string name, input vec_t v);
        int          cyc;
        int          stalls;
        logic        got;
        logic [31:0] res;
        logic        zf;
        drive(v);
        exp_q.push_back(v.exp);
        cyc    = 1;
        stalls = 0;
        got    = 1'b0;
        res    = '0;
        zf     = 1'b0;
        while (!got && cyc <= 100) begin
            #1;
            if (valid_o) begin
                got = 1'b1;
                res = result_o;
                zf  = zero_flag_o;
            end else begin
                if (stall_o) stalls++;
                @(negedge clk);
                cyc++;
                rs1_data_i      = $urandom;
                rs2_data_i      = $urandom;
                imm_ext_i       = $urandom;
                ex_mem_result_i = $urandom;
                mem_wb_result_i = $urandom;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s timeout actual=no valid_o required=valid_o within 100 cycles", name);
            void'(exp_q.pop_front());
        end else begin
            check($sformatf("%s result", name), res, exp_q.pop_front());
            check($sformatf("%s latency", name), 32'(cyc), 32'(v.lat));
            check($sformatf("%s stall_cycles", name), 32'(stalls), 32'(v.lat - 1));
            check($sformatf("%s zero_flag", name), {31'd0, zf}, {31'd0, v.exp == 32'd0});
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;

        // name           src op            md  md_op         fa          fb          rs1           rs2           imm      exm          mwb          expected      latency
        vecs.push_back(mk(0, ALU_OP_ADD, 0, MD_OP_MUL,    FWD_EX_MEM, FWD_REG,    32'hDEAD,     32'h5,        32'h0,   32'h10,      32'h0,       32'h15,       LAT_ALU));
        vecs.push_back(mk(0, ALU_OP_ADD, 1, MD_OP_MUL,    FWD_REG,    FWD_REG,    32'hFFFFFFFF, 32'h7,        32'h0,   32'h0,       32'h0,       32'hFFFFFFF9, LAT_MUL));
        vecs.push_back(mk(0, ALU_OP_ADD, 1, MD_OP_MULH,   FWD_REG,    FWD_REG,    32'hFFFFFFFF, 32'h7,        32'h0,   32'h0,       32'h0,       32'hFFFFFFFF, LAT_MUL));
        vecs.push_back(mk(0, ALU_OP_ADD, 1, MD_OP_MULHSU, FWD_REG,    FWD_REG,    32'h80000000, 32'h80000000, 32'h0,   32'h0,       32'h0,       32'hC0000000, LAT_MUL));
        vecs.push_back(mk(0, ALU_OP_ADD, 1, MD_OP_MULH,   FWD_REG,    FWD_REG,    32'h80000000, 32'h80000000, 32'h0,   32'h0,       32'h0,       32'h40000000, LAT_MUL));
        vecs.push_back(mk(0, ALU_OP_ADD, 1, MD_OP_DIV,    FWD_REG,    FWD_REG,    32'hFFFFFFF9, 32'h2,        32'h0,   32'h0,       32'h0,       32'hFFFFFFFD, LAT_DIV));
        vecs.push_back(mk(0, ALU_OP_ADD, 1, MD_OP_REM,    FWD_REG,    FWD_REG,    32'hFFFFFFF9, 32'h2,        32'h0,   32'h0,       32'h0,       32'hFFFFFFFF, LAT_DIV));
        vecs.push_back(mk(0, ALU_OP_ADD, 1, MD_OP_DIVU,   FWD_REG,    FWD_REG,    32'd100,      32'd7,        32'h0,   32'h0,       32'h0,       32'd14,       LAT_DIV));
        vecs.push_back(mk(0, ALU_OP_ADD, 1, MD_OP_REMU,   FWD_REG,    FWD_REG,    32'd100,      32'd7,        32'h0,   32'h0,       32'h0,       32'd2,        LAT_DIV));
        vecs.push_back(mk(0, ALU_OP_ADD, 1, MD_OP_DIV,    FWD_MEM_WB, FWD_REG,    32'h0,        32'hFFFFFFFA, 32'h0,   32'h0,       32'hFFFFFFEC, 32'd3,        LAT_DIV));
        vecs.push_back(mk(0, ALU_OP_ADD, 1, MD_OP_REM,    FWD_MEM_WB, FWD_REG,    32'h0,        32'hFFFFFFFA, 32'h0,   32'h0,       32'hFFFFFFEC, 32'hFFFFFFFE, LAT_DIV));
        vecs.push_back(mk(0, ALU_OP_ADD, 1, MD_OP_DIVU,   FWD_REG,    FWD_REG,    32'h1234,     32'h0,        32'h0,   32'h0,       32'h0,       32'hFFFFFFFF, LAT_FAST));
        vecs.push_back(mk(0, ALU_OP_ADD, 1, MD_OP_REM,    FWD_REG,    FWD_REG,    32'h1234,     32'h0,        32'h0,   32'h0,       32'h0,       32'h1234,     LAT_FAST));
        vecs.push_back(mk(0, ALU_OP_ADD, 1, MD_OP_DIV,    FWD_REG,    FWD_REG,    32'h80000000, 32'hFFFFFFFF, 32'h0,   32'h0,       32'h0,       32'h80000000, LAT_FAST));
        vecs.push_back(mk(0, ALU_OP_ADD, 1, MD_OP_REM,    FWD_REG,    FWD_REG,    32'h80000000, 32'hFFFFFFFF, 32'h0,   32'h0,       32'h0,       32'h0,        LAT_FAST));
        vecs.push_back(mk(1, ALU_OP_SUB, 0, MD_OP_MUL,    FWD_MEM_WB, FWD_EX_MEM, 32'h7,        32'h1,        32'h20,  32'h99,      32'h20,      32'h0,        LAT_ALU));
        vecs.push_back(mk(1, ALU_OP_ADD, 1, MD_OP_MUL,    FWD_REG,    FWD_EX_MEM, 32'd3,        32'h77,       32'd100, 32'd5,       32'h0,       32'd15,       LAT_MUL));
        vecs.push_back(mk(0, ALU_OP_SRA, 0, MD_OP_MUL,    2'b11,      2'b11,      32'h80000000, 32'd4,        32'h0,   32'h1,       32'h1,       32'hF8000000, LAT_ALU));

        // Reset state, with a live ALU op and then a live M op presented
        rst_n = 1'b0;
        drive(mk(0, ALU_OP_ADD, 0, MD_OP_MUL, FWD_REG, FWD_REG, 32'd5, 32'd6, 32'd0, 32'd0, 32'd0, 32'd0, 0));
        #2;
        check("reset valid_o", {31'd0, valid_o}, 32'd0);
        check("reset stall_o", {31'd0, stall_o}, 32'd0);
        check("reset result_o", result_o, 32'd0);
        check("reset zero_flag_o", {31'd0, zero_flag_o}, 32'd1);
        md_en_i = 1'b1;
        #1;
        check("reset stall_o md", {31'd0, stall_o}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        valid_i = 1'b0;
        md_en_i = 1'b0;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Flush in busy cycle 5 of a DIV, then an unstalled ADD
        drive(mk(0, ALU_OP_ADD, 1, MD_OP_DIVU, FWD_REG, FWD_REG, 32'd100, 32'd7, 32'd0, 32'd0, 32'd0, 32'd0, 0));
        repeat (5) @(negedge clk);
        #1;
        check("flush pre stall_o", {31'd0, stall_o}, 32'd1);
        flush_i = 1'b1;
        #1;
        check("flush stall_o", {31'd0, stall_o}, 32'd0);
        check("flush valid_o", {31'd0, valid_o}, 32'd0);
        @(negedge clk);
        drive(mk(0, ALU_OP_ADD, 0, MD_OP_MUL, FWD_REG, FWD_REG, 32'd3, 32'd4, 32'd0, 32'd0, 32'd0, 32'd0, 0));
        #1;
        check("post_flush add result", result_o, 32'd7);
        check("post_flush add valid_o", {31'd0, valid_o}, 32'd1);
        check("post_flush add stall_o", {31'd0, stall_o}, 32'd0);
        @(negedge clk);
        valid_i = 1'b0;
        #1;
        check("post_flush idle valid_o", {31'd0, valid_o}, 32'd0);
        @(negedge clk);

        // Reset pulsed mid-MUL while the M op is still presented
        v = mk(0, ALU_OP_ADD, 1, MD_OP_MUL, FWD_REG, FWD_REG, 32'h12345, 32'h678, 32'd0, 32'd0, 32'd0, 32'd0, 0);
        drive(v);
        repeat (4) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset valid_o", {31'd0, valid_o}, 32'd0);
        check("midreset stall_o", {31'd0, stall_o}, 32'd0);
        check("midreset result_o", result_o, 32'd0);
        check("midreset zero_flag_o", {31'd0, zero_flag_o}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec("mulhu_after_reset",
                mk(0, ALU_OP_ADD, 1, MD_OP_MULHU, FWD_REG, FWD_REG, 32'hFFFFFFFF, 32'hFFFFFFFF,
                   32'd0, 32'd0, 32'd0, 32'hFFFFFFFE, LAT_MUL));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_stage_md.md
# ex_stage_md

Parametrised execute stage for the RV32IM pipeline. It sits between the ID/EX and EX/MEM pipeline registers. It forwards operands from EX/MEM and MEM/WB, runs single-cycle integer ops through the existing `alu`, and runs M-extension ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) on an iterative multi-cycle engine that stalls the front of the pipe until its result is ready.

## Interface
- `XLEN`, 32: datapath width.
- `MUL_STEP`, 4: multiplier bits retired per cycle; one of {1,2,4,8}; must divide `XLEN`.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `valid_i` in 1: ID/EX holds a live instruction.
- `rs1_data_i`, `rs2_data_i`, `imm_ext_i` in XLEN: register and immediate operands.
- `alu_src_i` in 1: operand B source; 0 = forwarded rs2, 1 = imm.
- `alu_op_i` in 4: ALU opcode (package codes).
- `md_en_i` in 1: instruction is M-extension.
- `md_op_i` in 3: funct3 of the M op.
- `ex_mem_result_i`, `mem_wb_result_i` in XLEN: forwarding sources.
- `forward_a_sel_i`, `forward_b_sel_i` in 2: 00 = register, 01 = EX/MEM, 10 = MEM/WB, 11 = register.
- `flush_i` in 1: kill the current or in-flight op.
- `result_o` out XLEN: ALU or M result.
- `zero_flag_o` out 1: `result_o == 0`.
- `valid_o` out 1: `result_o` is final this cycle; EX/MEM may capture.
- `stall_o` out 1: hold PC, IF/ID and ID/EX this cycle.

## Operation
- Forwarding muxes operate as above. Operand B = imm when `alu_src_i`=1. M ops always use forwarded rs2.
- ALU path (`md_en_i`=0, state IDLE): combinational. `valid_o`=`valid_i`, `stall_o`=0.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE + `valid_i` & `md_en_i`: `stall_o`=1 combinationally. At the edge, the engine captures operand magnitudes, sign flags and op, then moves to MUL or DIV.
  - Fast path to DONE when the divisor is 0, or on signed overflow (DIV/REM of −2^(XLEN−1) by −1).
- MUL: shift-add of `MUL_STEP` bits per cycle over a 2·XLEN accumulator, `XLEN/MUL_STEP` cycles.
  - The product is negated when the operand signs differ (MULH: both signed; MULHSU: rs1 signed; MULHU/MUL: unsigned).
  - MUL returns the low word; the MULH variants return the high word.
- DIV: restoring radix-2 on magnitudes, XLEN cycles.
  - Quotient sign = sign(rs1) XOR sign(rs2); remainder sign = sign(rs1); applied when entering DONE.
- Divide by zero: quotient = all ones, remainder = rs1.
- Signed overflow: quotient = 0x8000_0000 (−2^(XLEN−1)), remainder = 0.
- DONE: `result_o` = registered M result, `valid_o`=1, `stall_o`=0. The next edge returns to IDLE while the pipe advances.
- `flush_i`: masks `stall_o` and `valid_o` combinationally. Next edge: state IDLE, counter cleared, no result emitted. `flush_i` has priority over accept.
- Reset (asynchronous, any state): state IDLE, counter 0, accumulators 0.
  - While `rst_n`=0: `valid_o`=0, `stall_o`=0, `result_o`=0, `zero_flag_o`=1.

## Timing
- ALU op: 0-cycle latency, result in the issue cycle.
- M op occupancy (ID/EX held): accept cycle + N busy cycles + DONE cycle.
  - `stall_o` is high for 1+N cycles; `valid_o` is high only in DONE.
  - MUL: N = XLEN/MUL_STEP, giving 10 cycles total at defaults.
  - DIV/REM: N = XLEN, giving 34 cycles total.
  - Fast path: N = 0, giving 2 cycles total.
- ID/EX inputs may change during busy cycles and are ignored; operands are sampled only at the accept edge.
- Iteration counter width: $clog2(XLEN)+1. No back-to-back accept: DONE always returns to IDLE first.

## Structure
- Package `ex_pkg`:
  - `ALU_OP_*` codes.
  - `MD_OP_*` funct3 codes.
  - `FWD_REG`/`FWD_EX_MEM`/`FWD_MEM_WB` encodings.
  - FSM state enum.
- One sub-module: `muldiv_iter`, containing the FSM, counter, accumulators and sign fixup, with a start/flush/done interface.
- The top level instantiates `alu` and `muldiv_iter` and owns the forwarding and output muxes.

## Test plan
- Forwarded ADD: `forward_a_sel_i`=01, `ex_mem_result_i`=0x10, `rs2_data_i`=0x5, add → `result_o`=0x15 in the same cycle, `stall_o`=0.
- MUL/MULH with rs1=0xFFFFFFFF, rs2=7 → MUL 0xFFFFFFF9, MULH 0xFFFFFFFF.
  - `stall_o` high exactly 9 cycles, then `valid_o` on the 10th.
- DIV/REM with −7 / 2 → 0xFFFFFFFD / 0xFFFFFFFF; DIVU 100 / 7 → 14.
  - `valid_o` on cycle 34.
- Corner cases, each with `valid_o` on cycle 2:
  - DIVU 0x1234 / 0 → 0xFFFFFFFF.
  - REM 0x1234 / 0 → 0x1234.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, REM → 0.
- `flush_i` in busy cycle 5 of a DIV → `stall_o` low that cycle, no `valid_o`. A following ADD 3+4 → 7, unstalled.
- `rst_n` pulsed low mid-MUL → outputs drop to reset values immediately. After release, MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE in 10 cycles.
